// File: rtl/ysyx_22040759_axi_rd_bridge_pkg.sv
// Shared AXI constants and FSM encodings for the single-port read bridge.
// Also holds the helper that classifies an R beat as an error.
package ysyx_22040759_axi_rd_bridge_pkg;

    localparam logic [2:0] SIZE_8B    = 3'b011;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [7:0] LEN_SINGLE = 8'd0;

    localparam int ST_IDLE_BIT = 0;
    localparam int ST_AR_BIT   = 1;
    localparam int ST_R_BIT    = 2;
    localparam int ST_RESP_BIT = 3;

    typedef enum logic [3:0] {
        RD_IDLE = 4'b0001,
        RD_AR   = 4'b0010,
        RD_R    = 4'b0100,
        RD_RESP = 4'b1000
    } rd_state_e;

    // A single-beat read must end with r_last; anything else is a protocol error.
    function automatic logic rd_beat_err(input logic [1:0] resp, input logic last);
        return (resp != RESP_OKAY) || !last;
    endfunction

endpackage

// File: rtl/ysyx_22040759_axi_rd_bridge.sv
// Turns each request on the shared read port into one single-beat AXI4 read
// and returns the beat as a one-cycle pulse. One transaction in flight at most.
module ysyx_22040759_axi_rd_bridge
    import ysyx_22040759_axi_rd_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int AXI_ID = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_addr_valid,
    input  logic [63:0]       rd_addr,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_resp_err,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,
    output logic [ID_W-1:0]   ar_id,
    output logic [7:0]        ar_len,
    output logic [2:0]        ar_size,
    output logic [1:0]        ar_burst,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [DATA_W-1:0] r_data,
    input  logic [1:0]        r_resp,
    input  logic              r_last
);

    rd_state_e         state_r;
    rd_state_e         state_nxt_s;
    logic [ADDR_W-1:0] ar_addr_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              err_r;
    logic              req_take_s;
    logic              beat_take_s;
    logic              unused_addr_s;

    assign req_take_s    = state_r[ST_IDLE_BIT] && rd_addr_valid;
    assign beat_take_s   = state_r[ST_R_BIT] && r_valid;
    assign unused_addr_s = ^{rd_addr[63:ADDR_W], rd_addr[2:0]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RD_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; RESP always returns to IDLE so a held request is resampled there.
    always_comb begin
        state_nxt_s = RD_IDLE;
        case (state_r)
            RD_IDLE: begin
                if (rd_addr_valid) begin
                    state_nxt_s = RD_AR;
                end else begin
                    state_nxt_s = RD_IDLE;
                end
            end
            RD_AR: begin
                if (ar_ready) begin
                    state_nxt_s = RD_R;
                end else begin
                    state_nxt_s = RD_AR;
                end
            end
            RD_R: begin
                if (r_valid) begin
                    state_nxt_s = RD_RESP;
                end else begin
                    state_nxt_s = RD_R;
                end
            end
            RD_RESP: state_nxt_s = RD_IDLE;
            default: state_nxt_s = RD_IDLE;
        endcase
    end

    // Address latched on acceptance so later rd_addr changes cannot disturb AR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_addr_r <= '0;
        end else if (req_take_s) begin
            ar_addr_r <= {rd_addr[ADDR_W-1:3], 3'b000};
        end else begin
            ar_addr_r <= ar_addr_r;
        end
    end

    // Beat capture; rd_data keeps the last response until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= '0;
            err_r     <= 1'b0;
        end else if (beat_take_s) begin
            rd_data_r <= r_data;
            err_r     <= rd_beat_err(r_resp, r_last);
        end else begin
            rd_data_r <= rd_data_r;
            err_r     <= err_r;
        end
    end

    // Outputs come straight from one-hot state flops and data registers.
    always_comb begin
        ar_valid      = 1'b0;
        r_ready       = 1'b0;
        rd_data_valid = 1'b0;
        rd_resp_err   = 1'b0;
        ar_valid      = state_r[ST_AR_BIT];
        r_ready       = state_r[ST_R_BIT];
        rd_data_valid = state_r[ST_RESP_BIT];
        rd_resp_err   = state_r[ST_RESP_BIT] && err_r;
    end

    assign ar_addr  = ar_addr_r;
    assign rd_data  = rd_data_r;
    assign ar_id    = ID_W'(AXI_ID);
    assign ar_len   = LEN_SINGLE;
    assign ar_size  = SIZE_8B;
    assign ar_burst = BURST_INCR;

endmodule

// File: tb/tb_ysyx_22040759_axi_rd_bridge.sv
// Directed self-checking bench for the AXI read bridge.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ysyx_22040759_axi_rd_bridge;

    logic        clk;
    logic        rst_n;
    logic        rd_addr_valid;
    logic [63:0] rd_addr;
    logic        rd_data_valid;
    logic [63:0] rd_data;
    logic        rd_resp_err;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic [3:0]  ar_id;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid;
    logic        r_ready;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;

    int n_checks;
    int n_fail;

    ysyx_22040759_axi_rd_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_valid(rd_addr_valid), .rd_addr(rd_addr),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_resp_err(rd_resp_err),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .r_resp(r_resp), .r_last(r_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, ".ar_valid"}, {63'd0, ar_valid}, 64'd0);
        check({tag, ".r_ready"}, {63'd0, r_ready}, 64'd0);
        check({tag, ".rd_data_valid"}, {63'd0, rd_data_valid}, 64'd0);
        check({tag, ".rd_resp_err"}, {63'd0, rd_resp_err}, 64'd0);
    endtask

    int ar_cnt;
    int pulse_cnt;
    logic found;

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        rd_addr_valid = 1'b0;
        rd_addr = 64'd0;
        ar_ready = 1'b0;
        r_valid = 1'b0;
        r_data = 64'd0;
        r_resp = 2'b00;
        r_last = 1'b1;
        step();
        step();
        // reset state
        check_idle_outs("reset");
        check("reset.ar_addr", {32'd0, ar_addr}, 64'd0);
        check("reset.rd_data", rd_data, 64'd0);
        rst_n = 1'b1;
        step();
        check("const.ar_id", {60'd0, ar_id}, 64'd0);
        check("const.ar_len", {56'd0, ar_len}, 64'd0);
        check("const.ar_size", {61'd0, ar_size}, 64'd3);
        check("const.ar_burst", {62'd0, ar_burst}, 64'd1);

        // 1: zero-wait read
        rd_addr_valid = 1'b1;
        rd_addr = 64'h8000_0004;
        ar_ready = 1'b1;
        r_valid = 1'b1;
        r_data = 64'h1122_3344_5566_7788;
        step();
        check("t1.c1.ar_valid", {63'd0, ar_valid}, 64'd1);
        check("t1.c1.ar_addr", {32'd0, ar_addr}, 64'h8000_0000);
        check("t1.c1.r_ready", {63'd0, r_ready}, 64'd0);
        step();
        check("t1.c2.r_ready", {63'd0, r_ready}, 64'd1);
        check("t1.c2.ar_valid", {63'd0, ar_valid}, 64'd0);
        check("t1.c2.rd_data_valid", {63'd0, rd_data_valid}, 64'd0);
        step();
        check("t1.c3.rd_data_valid", {63'd0, rd_data_valid}, 64'd1);
        check("t1.c3.rd_data", rd_data, 64'h1122_3344_5566_7788);
        check("t1.c3.err", {63'd0, rd_resp_err}, 64'd0);
        rd_addr_valid = 1'b0;
        r_valid = 1'b0;
        step();
        check_idle_outs("t1.c4");
        check("t1.c4.rd_data_hold", rd_data, 64'h1122_3344_5566_7788);

        // 2: stalls on AR and R
        ar_ready = 1'b0;
        rd_addr_valid = 1'b1;
        rd_addr = 64'h0000_0001_0000_1237;
        step();
        for (int i = 0; i < 4; i++) begin
            check("t2.ar_hold", {63'd0, ar_valid}, 64'd1);
            check("t2.ar_addr_stable", {32'd0, ar_addr}, 64'h0000_1230);
            rd_addr = 64'hFFFF_FFFF_FFFF_FFF8;
            if (i < 3) step();
        end
        ar_ready = 1'b1;
        step();
        ar_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t2.r_wait", {63'd0, r_ready}, 64'd1);
            check("t2.no_pulse", {63'd0, rd_data_valid}, 64'd0);
            check("t2.ar_dropped", {63'd0, ar_valid}, 64'd0);
            if (i < 2) step();
        end
        r_valid = 1'b1;
        r_data = 64'hDEAD_BEEF_0000_0001;
        step();
        r_valid = 1'b0;
        rd_addr_valid = 1'b0;
        check("t2.pulse", {63'd0, rd_data_valid}, 64'd1);
        check("t2.data", rd_data, 64'hDEAD_BEEF_0000_0001);
        step();
        check("t2.pulse_one_cycle", {63'd0, rd_data_valid}, 64'd0);

        // 3: back-to-back with rd_addr_valid held high
        ar_ready = 1'b1;
        r_valid = 1'b1;
        r_data = 64'hAAAA_0000_0000_0001;
        rd_addr_valid = 1'b1;
        rd_addr = 64'h8000_0000;
        ar_cnt = 0;
        pulse_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (ar_valid) ar_cnt++;
            if (rd_data_valid) pulse_cnt++;
            if (c == 1) check("t3.ar1_addr", {32'd0, ar_addr}, 64'h8000_0000);
            if (c == 3) begin
                check("t3.pulse1", {63'd0, rd_data_valid}, 64'd1);
                check("t3.data1", rd_data, 64'hAAAA_0000_0000_0001);
                rd_addr = 64'h8000_0008;
                r_data = 64'hBBBB_0000_0000_0002;
            end
            if (c == 4) check_idle_outs("t3.idle_gap");
            if (c == 5) begin
                check("t3.ar2_valid", {63'd0, ar_valid}, 64'd1);
                check("t3.ar2_addr", {32'd0, ar_addr}, 64'h8000_0008);
            end
            if (c == 7) begin
                check("t3.pulse2", {63'd0, rd_data_valid}, 64'd1);
                check("t3.data2", rd_data, 64'hBBBB_0000_0000_0002);
                rd_addr_valid = 1'b0;
            end
        end
        check("t3.ar_count", 64'(ar_cnt), 64'd2);
        check("t3.pulse_count", 64'(pulse_cnt), 64'd2);

        // 4: error response, then OKAY clears it
        r_resp = 2'b10;
        r_data = 64'h0000_0000_0000_0E11;
        rd_addr_valid = 1'b1;
        rd_addr = 64'h8000_0010;
        step(); step(); step();
        check("t4.err_pulse", {63'd0, rd_data_valid}, 64'd1);
        check("t4.err", {63'd0, rd_resp_err}, 64'd1);
        r_resp = 2'b00;
        r_data = 64'h0000_0000_0000_0600;
        step();
        check("t4.err_cleared_idle", {63'd0, rd_resp_err}, 64'd0);
        step(); step(); step();
        check("t4.ok_pulse", {63'd0, rd_data_valid}, 64'd1);
        check("t4.ok_err", {63'd0, rd_resp_err}, 64'd0);
        check("t4.ok_data", rd_data, 64'h0000_0000_0000_0600);
        rd_addr_valid = 1'b0;
        r_last = 1'b0;
        step();
        // OKAY without r_last is still flagged
        rd_addr_valid = 1'b1;
        step(); step(); step();
        check("t4.nolast_err", {63'd0, rd_resp_err}, 64'd1);
        rd_addr_valid = 1'b0;
        r_last = 1'b1;
        step();

        // 5: async reset while waiting in R
        r_valid = 1'b0;
        rd_addr_valid = 1'b1;
        rd_addr = 64'h8000_0020;
        step(); step();
        check("t5.in_r", {63'd0, r_ready}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outs("t5.async");
        check("t5.ar_addr", {32'd0, ar_addr}, 64'd0);
        check("t5.rd_data", rd_data, 64'd0);
        rd_addr_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        r_valid = 1'b1;
        r_data = 64'h5555_6666_7777_8888;
        rd_addr_valid = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (rd_data_valid && !found) begin
                found = 1'b1;
                check("t5.latency", 64'(c + 1), 64'd3);
                check("t5.data", rd_data, 64'h5555_6666_7777_8888);
                rd_addr_valid = 1'b0;
            end
        end
        check("t5.completed", {63'd0, found}, 64'd1);
        r_valid = 1'b0;

        // 6: request withdrawn during AR
        ar_ready = 1'b0;
        rd_addr_valid = 1'b1;
        rd_addr = 64'h8000_0030;
        step();
        rd_addr_valid = 1'b0;
        step();
        check("t6.ar_kept", {63'd0, ar_valid}, 64'd1);
        ar_ready = 1'b1;
        step();
        check("t6.r_ready", {63'd0, r_ready}, 64'd1);
        r_valid = 1'b1;
        r_data = 64'h0606_0606_0606_0606;
        step();
        r_valid = 1'b0;
        check("t6.pulse", {63'd0, rd_data_valid}, 64'd1);
        check("t6.data", rd_data, 64'h0606_0606_0606_0606);
        step();
        check_idle_outs("t6.idle");
        step();
        check("t6.no_new_ar", {63'd0, ar_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
